// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width helpers and per-memory-type read latency defaults
package fifo_pkg;
  localparam int M20K_READ_LATENCY = 4;
  localparam int MLAB_READ_LATENCY = 3;
  function automatic int clogw(input int n);
    int w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
  function automatic int ptr_width(input int depthLog2);
    return depthLog2 + 1;
  endfunction
endpackage

// File: rtl/lookahead_output_buffer.sv
// lookahead_output_buffer: small circular register FIFO holding prefetched words
// ports: clk, rst_n, push/pushData (write side), pop (ignored when empty),
// head (oldest word), notEmpty, count (words held)
module lookahead_output_buffer
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OUT_DEPTH = 6,
  localparam int IW = clogw(OUT_DEPTH),
  localparam int CW = clogw(OUT_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             notEmpty,
  output logic [CW-1:0]    count
);
  localparam logic [IW-1:0] LAST = IW'(OUT_DEPTH - 1);
  logic [WIDTH-1:0] regs [OUT_DEPTH];
  logic [IW-1:0] wp, rp;
  logic doPop;
  assign notEmpty = count != '0;
  assign doPop = pop && notEmpty;
  assign head = regs[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) regs[i] <= '0;
    end else begin
      if (push) begin
        regs[wp] <= pushData;
        wp <= wp == LAST ? '0 : wp + 1'b1;
      end
      if (doPop) rp <= rp == LAST ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(doPop);
    end
endmodule

// File: rtl/lookahead_fifo_m20k.sv
// lookahead_fifo_m20k: single-clock FIFO with credit-tracked prefetch into a lookahead output buffer
// ports: clk, rst_n, writeEnable/dataIn (push side), almostFull, full, overflow (sticky),
// grab/dataAvailable/dataOut (lookahead pop side), usedWords (total words held)
module lookahead_fifo_m20k
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH_LOG2 = 9,
  parameter int READ_LATENCY = M20K_READ_LATENCY,
  parameter int ALMOST_FULL_MARGIN = 50,
  parameter int OUT_DEPTH = READ_LATENCY + 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  writeEnable,
  input  logic [WIDTH-1:0]      dataIn,
  output logic                  almostFull,
  output logic                  full,
  output logic                  overflow,
  input  logic                  grab,
  output logic                  dataAvailable,
  output logic [WIDTH-1:0]      dataOut,
  output logic [DEPTH_LOG2+1:0] usedWords
);
  localparam int PW = ptr_width(DEPTH_LOG2);
  localparam int CW = clogw(OUT_DEPTH + 1);
  logic [PW-1:0] writeAddr, readAddr, memCount;
  logic [CW-1:0] inFlight, bufCount;
  logic [CW:0] credits;
  logic [READ_LATENCY-1:0] validPipe;
  logic [WIDTH-1:0] dataPipe [READ_LATENCY];
  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic empty, doWrite, doRead, doPop;
  assign memCount = writeAddr - readAddr;
  assign empty = writeAddr == readAddr;
  assign full = writeAddr[PW-1] != readAddr[PW-1] && writeAddr[PW-2:0] == readAddr[PW-2:0];
  assign doWrite = writeEnable && !full;
  assign doPop = grab && dataAvailable;
  assign credits = (CW+1)'(inFlight) + (CW+1)'(bufCount);
  // a grab this cycle frees a slot, so a full credit pool can still issue and keep streaming
  assign doRead = !empty && (credits < (CW+1)'(OUT_DEPTH) || doPop);
  assign usedWords = (DEPTH_LOG2+2)'(memCount) + (DEPTH_LOG2+2)'(inFlight) + (DEPTH_LOG2+2)'(bufCount);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      writeAddr <= '0;
      readAddr <= '0;
      inFlight <= '0;
      validPipe <= '0;
      overflow <= 1'b0;
      almostFull <= 1'b0;
    end else begin
      writeAddr <= writeAddr + PW'(doWrite);
      readAddr <= readAddr + PW'(doRead);
      inFlight <= inFlight + CW'(doRead) - CW'(validPipe[READ_LATENCY-1]);
      validPipe[0] <= doRead;
      for (int i = 1; i < READ_LATENCY; i++) validPipe[i] <= validPipe[i-1];
      overflow <= overflow || (writeEnable && full);
      almostFull <= (2**DEPTH_LOG2 - int'(memCount)) < ALMOST_FULL_MARGIN;
    end
  // memory array with readEnable permanently high; data follows the valid pipe
  always_ff @(posedge clk) begin
    if (doWrite) mem[writeAddr[PW-2:0]] <= dataIn;
    dataPipe[0] <= mem[readAddr[PW-2:0]];
    for (int i = 1; i < READ_LATENCY; i++) dataPipe[i] <= dataPipe[i-1];
  end
  lookahead_output_buffer #(.WIDTH(WIDTH), .OUT_DEPTH(OUT_DEPTH)) outBuf (
    .clk(clk),
    .rst_n(rst_n),
    .push(validPipe[READ_LATENCY-1]),
    .pushData(dataPipe[READ_LATENCY-1]),
    .pop(grab),
    .head(dataOut),
    .notEmpty(dataAvailable),
    .count(bufCount)
  );
endmodule

// File: tb/tb_lookahead_fifo_m20k.sv
// tb_lookahead_fifo_m20k: directed and scoreboarded checks of the lookahead FIFO
module tb_lookahead_fifo_m20k;
  logic clk = 0, rst_n = 0, writeEnable = 0, grab = 0;
  logic [15:0] dataIn = 0, dataOut;
  logic almostFull, full, overflow, dataAvailable;
  logic [10:0] usedWords;
  int checks = 0, errors = 0;
  logic [15:0] q[$];
  lookahead_fifo_m20k dut (
    .clk(clk), .rst_n(rst_n), .writeEnable(writeEnable), .dataIn(dataIn),
    .almostFull(almostFull), .full(full), .overflow(overflow), .grab(grab),
    .dataAvailable(dataAvailable), .dataOut(dataOut), .usedWords(usedWords)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 0; writeEnable = 0; grab = 0; dataIn = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    q.delete();
    @(posedge clk); #1;
  endtask
  task automatic cycle(input logic we, input logic [15:0] d, input logic gr);
    writeEnable = we; dataIn = d; grab = gr;
    if (gr && dataAvailable) begin
      if (q.size() == 0) check("spurious_data", dataAvailable, 0);
      else check("pop_data", dataOut, q.pop_front());
    end
    if (we && !full) q.push_back(d);
    @(posedge clk); #1;
    check("used_words", usedWords, q.size());
  endtask
  task automatic drain(input int bound);
    for (int n = 0; n < bound && q.size() > 0; n++) cycle(0, 0, 1);
    check("drain_empty", q.size(), 0);
  endtask
  initial begin
    int started, gaps, maxCred;
    do_reset();
    check("rst_avail", dataAvailable, 0);
    check("rst_dout", dataOut, 0);
    check("rst_used", usedWords, 0);
    check("rst_full", full, 0);
    check("rst_afull", almostFull, 0);
    check("rst_ovf", overflow, 0);
    // single word latency: write at cycle 0, visible at cycle 6
    cycle(1, 16'hA5A5, 0);
    repeat (4) cycle(0, 0, 0);
    check("lat_c5_avail", dataAvailable, 0);
    cycle(0, 0, 0);
    check("lat_c6_avail", dataAvailable, 1);
    check("lat_c6_dout", dataOut, 16'hA5A5);
    cycle(0, 0, 0);
    cycle(0, 0, 1);
    check("single_c8_avail", dataAvailable, 0);
    check("single_c8_used", usedWords, 0);
    // streaming with grab held high
    started = 0; gaps = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1, 16'(i), 1);
      if (dataAvailable) started = 1;
      else if (started != 0 && q.size() > 0) gaps++;
    end
    check("stream_gaps", gaps, 0);
    drain(50);
    // fill: 6 words prefetch out of memory, so memory is full after 518 writes
    do_reset();
    for (int i = 0; i < 517; i++) begin
      cycle(1, 16'(i), 0);
      if (i == 10) check("afull_low", almostFull, 0);
    end
    check("fill_not_full", full, 0);
    cycle(1, 16'd517, 0);
    check("fill_full", full, 1);
    check("fill_afull", almostFull, 1);
    check("fill_used", usedWords, 518);
    check("fill_no_ovf", overflow, 0);
    cycle(1, 16'hDEAD, 0);
    check("ovf_set", overflow, 1);
    check("ovf_used", usedWords, 518);
    drain(600);
    check("ovf_sticky", overflow, 1);
    check("drain_afull", almostFull, 0);
    check("drain_full", full, 0);
    // sparse bursts with random grab
    do_reset();
    maxCred = 0;
    for (int k = 0; k < 30; k++) begin
      cycle(1, 16'(16'h100 + k), 1'($urandom_range(0, 1)));
      if (int'(dut.credits) > maxCred) maxCred = int'(dut.credits);
      cycle(0, 0, 1'($urandom_range(0, 1)));
      if (int'(dut.credits) > maxCred) maxCred = int'(dut.credits);
    end
    drain(100);
    check("credits_bounded", maxCred <= 6, 1);
    // random traffic across the pointer wrap
    for (int k = 0; k < 3000; k++)
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    drain(600);
    // reset with 3 reads in flight and 2 words buffered
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1, 16'(16'h50 + k), 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    check("pre_rst_avail", dataAvailable, 1);
    check("pre_rst_buf", dut.bufCount, 2);
    check("pre_rst_inflight", dut.inFlight, 3);
    rst_n = 0; #1;
    check("midrst_avail", dataAvailable, 0);
    check("midrst_dout", dataOut, 0);
    check("midrst_used", usedWords, 0);
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    q.delete();
    @(posedge clk); #1;
    repeat (8) cycle(0, 0, 1);
    check("post_rst_avail", dataAvailable, 0);
    cycle(1, 16'h1234, 0);
    drain(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
